controladora_multicanal: RTL and testbench

Multi-channel lighting controller: N_CH independent lamp channels, each with its own push button and infrared presence sensor. Each channel runs its own debounce, long-press mode switch, manual lamp toggle and auto-shutdown timer. It is the parametrised successor to the single-channel `controladora` and sits between board-level button/sensor inputs and the lamp drivers.

---
 rtl/controladora_multicanal.sv | 153 +++++++++++++++
 tb/tb_controladora_multicanal.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controladora_multicanal.sv
// Multi-channel lighting controller: per-channel debounce, long-press mode switch,
// manual toggle and auto-shutdown timer. Optional CONTROLADORA_SYNC_EN adds 2-flop input synchronisers.
module controladora_multicanal #(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5300,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] push_button,
    input  logic [N_CH-1:0] infravermelho,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] saida
);

    localparam int DB_W = $clog2(DEBOUNCE_P + 1);
    localparam int PR_W = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int TM_W = $clog2(AUTO_SHUTDOWN_T + 1);

    typedef enum logic [1:0] {
        AUTO_OFF,
        AUTO_ON,
        MANUAL_OFF,
        MANUAL_ON
    } state_t;

    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] ir_in;

`ifdef CONTROLADORA_SYNC_EN
    logic [N_CH-1:0] btn_s1, btn_s2, ir_s1, ir_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            ir_s1  <= '0;
            ir_s2  <= '0;
        end else begin
            btn_s1 <= push_button;
            btn_s2 <= btn_s1;
            ir_s1  <= infravermelho;
            ir_s2  <= ir_s1;
        end
    end

    assign btn_in = btn_s2;
    assign ir_in  = ir_s2;
`else
    assign btn_in = push_button;
    assign ir_in  = infravermelho;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DB_W-1:0] db_cnt;
        logic            btn_db;
        logic            btn_db_q;
        logic [PR_W-1:0] press_cnt;
        logic [TM_W-1:0] timer;
        state_t          state;
        logic            led_r;
        logic            saida_r;
        logic            release_ev;
        logic            long_press;
        logic            short_press;

        // Release is judged one cycle after btn_db falls, using the saturated press length.
        assign release_ev  = btn_db_q & ~btn_db;
        assign long_press  = release_ev && (press_cnt >= PR_W'(SWITCH_MODE_MIN_T));
        assign short_press = release_ev && (press_cnt < PR_W'(SWITCH_MODE_MIN_T));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_cnt    <= '0;
                btn_db    <= 1'b0;
                btn_db_q  <= 1'b0;
                press_cnt <= '0;
            end else begin
                btn_db_q <= btn_db;
                if (btn_in[i] == btn_db) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_P - 1)) begin
                    btn_db <= btn_in[i];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end

                if (release_ev)
                    press_cnt <= '0;
                else if (btn_db && press_cnt != PR_W'(SWITCH_MODE_MIN_T))
                    press_cnt <= press_cnt + PR_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= AUTO_OFF;
                timer   <= '0;
                led_r   <= 1'b0;
                saida_r <= 1'b0;
            end else begin
                led_r   <= (state == MANUAL_OFF) || (state == MANUAL_ON);
                saida_r <= (state == AUTO_ON) || (state == MANUAL_ON);
                case (state)
                    AUTO_OFF: begin
                        timer <= '0;
                        if (long_press)
                            state <= MANUAL_OFF;
                        else if (ir_in[i])
                            state <= AUTO_ON;
                    end
                    AUTO_ON: begin
                        if (long_press) begin
                            state <= MANUAL_ON;
                            timer <= '0;
                        end else if (ir_in[i]) begin
                            timer <= '0;
                        end else if (timer == TM_W'(AUTO_SHUTDOWN_T - 1)) begin
                            state <= AUTO_OFF;
                            timer <= '0;
                        end else begin
                            timer <= timer + TM_W'(1);
                        end
                    end
                    MANUAL_OFF: begin
                        timer <= '0;
                        if (long_press)
                            state <= AUTO_OFF;
                        else if (short_press)
                            state <= MANUAL_ON;
                    end
                    MANUAL_ON: begin
                        timer <= '0;
                        if (long_press)
                            state <= AUTO_OFF;
                        else if (short_press)
                            state <= MANUAL_OFF;
                    end
                    default: begin
                        state <= AUTO_OFF;
                        timer <= '0;
                    end
                endcase
            end
        end

        assign led[i]   = led_r;
        assign saida[i] = saida_r;
    end

endmodule

// File: tb/tb_controladora_multicanal.sv
// Self-checking bench for controladora_multicanal: directed scenarios plus random
// button/IR traffic checked every cycle against an event-time reference model.
module tb_controladora_multicanal;

    localparam int N   = 2;
    localparam int P   = 4;
    localparam int MIN = 20;
    localparam int T   = 50;
    localparam int NEVER = -1000000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pb  = '0;
    logic [N-1:0] ir  = '0;
    logic [N-1:0] led;
    logic [N-1:0] saida;

    controladora_multicanal #(
        .N_CH             (N),
        .DEBOUNCE_P       (P),
        .SWITCH_MODE_MIN_T(MIN),
        .AUTO_SHUTDOWN_T  (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_button  (pb),
        .infravermelho(ir),
        .led          (led),
        .saida        (saida)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_k = 0;

    // Model state, kept as event times rather than counters
    int           last_agree [N];
    bit           db         [N];
    bit           pending    [N];
    int           press_len  [N];
    int           rise_t     [N];
    bit           manual     [N];
    bit           lamp       [N];
    int           last_ir    [N];
    logic [N-1:0] exp_led;
    logic [N-1:0] exp_saida;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_k);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            last_agree[c] = edge_k;
            db[c]         = 1'b0;
            pending[c]    = 1'b0;
            press_len[c]  = 0;
            rise_t[c]     = 0;
            manual[c]     = 1'b0;
            lamp[c]       = 1'b0;
            last_ir[c]    = NEVER;
        end
        exp_led   = '0;
        exp_saida = '0;
    endtask

    task automatic model_edge();
        bit lp, sp;
        edge_k++;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            exp_led[c]   = manual[c];
            exp_saida[c] = lamp[c];
            lp = 1'b0;
            sp = 1'b0;
            if (pending[c]) begin
                lp = (press_len[c] >= MIN);
                sp = !lp;
                pending[c] = 1'b0;
            end
            if (lp) begin
                if (manual[c]) begin
                    manual[c]  = 1'b0;
                    lamp[c]    = 1'b0;
                    last_ir[c] = NEVER;
                end else begin
                    manual[c] = 1'b1;
                end
            end else if (manual[c]) begin
                if (sp) lamp[c] = !lamp[c];
            end else if (ir[c]) begin
                lamp[c]    = 1'b1;
                last_ir[c] = edge_k;
            end else if (lamp[c] && (edge_k - last_ir[c] >= T)) begin
                lamp[c] = 1'b0;
            end
            // Level accepted once it has differed for P consecutive samples
            if (pb[c] == db[c]) begin
                last_agree[c] = edge_k;
            end else if (edge_k - last_agree[c] >= P) begin
                db[c]         = pb[c];
                last_agree[c] = edge_k;
                if (db[c]) begin
                    rise_t[c] = edge_k;
                end else begin
                    pending[c]   = 1'b1;
                    press_len[c] = (edge_k - rise_t[c] > MIN) ? MIN : edge_k - rise_t[c];
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic [N-1:0] i);
        pb = b;
        ir = i;
        @(posedge clk);
        model_edge();
        #1;
        check("led", led, exp_led);
        check("saida", saida, exp_saida);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("async_reset_led", led, '0);
        check("async_reset_saida", saida, '0);
    endtask

    initial begin
        int cnt;
        int hold [N];
        logic [N-1:0] rb, ri;

        #1;
        assert_reset();
        repeat (10) step(N'($urandom), N'($urandom));
        rst = 1'b1;
        repeat (3) step('0, '0);
        check("post_reset_led", led, 2'b00);

        // Bounce shorter than the debounce window
        repeat (10) begin
            repeat (3) step(2'b01, 2'b00);
            repeat (3) step(2'b00, 2'b00);
        end
        repeat (P + 4) step('0, '0);
        check("bounce_led", led, 2'b00);

        // Long press on ch1, then two short toggles
        repeat (30) step(2'b10, 2'b00);
        repeat (P + 4) step('0, '0);
        check("long_press_led", led, 2'b10);
        repeat (10) step(2'b10, 2'b00);
        repeat (P + 4) step('0, '0);
        check("short_on_saida", saida, 2'b10);
        repeat (10) step(2'b10, 2'b00);
        repeat (P + 4) step('0, '0);
        check("short_off_saida", saida, 2'b00);

        // Auto timeout on ch0: edges counted from the pulse edge
        step(2'b00, 2'b01);
        cnt = 0;
        while (saida[0] !== 1'b1 && cnt < 10) begin step('0, '0); cnt++; end
        check_int("ir_rise_latency", cnt, 1);
        while (saida[0] === 1'b1 && cnt < 200) begin step('0, '0); cnt++; end
        check_int("ir_shutdown_edges", cnt, T + 1);

        step(2'b00, 2'b01);
        cnt = 0;
        repeat (39) begin step('0, '0); cnt++; end
        step(2'b00, 2'b01);
        cnt++;
        while (saida[0] === 1'b1 && cnt < 300) begin step('0, '0); cnt++; end
        check_int("ir_extend_edges", cnt, 40 + T + 1);

        // Long press from AUTO_ON keeps the lamp lit in manual
        step(2'b00, 2'b01);
        repeat (30) step(2'b01, 2'b00);
        repeat (P + 4) step('0, '0);
        check("preserve_led", led, 2'b11);
        repeat (210) step('0, '0);
        check("preserve_saida", saida, 2'b01);
        repeat (30) step(2'b01, 2'b00);
        repeat (P + 4) step('0, '0);
        check("back_auto_led", led, 2'b10);
        check("back_auto_saida", saida, 2'b00);

        // Reset during a debounced hold discards the press
        repeat (P + 15) step(2'b01, 2'b00);
        assert_reset();
        repeat (3) step(2'b01, 2'b00);
        rst = 1'b1;
        repeat (P + 6) step('0, '0);
        check("reset_mid_press_led", led, 2'b00);

        // Random traffic
        for (int c = 0; c < N; c++) hold[c] = 0;
        rb = '0;
        for (int k = 0; k < 3000; k++) begin
            ri = '0;
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    rb[c]   = 1'($urandom);
                    hold[c] = $urandom_range(1, 30);
                end
                hold[c]--;
                ri[c] = ($urandom_range(0, 39) == 0);
            end
            if (k == 1700) begin
                assert_reset();
                step(rb, ri);
                rst = 1'b1;
            end else begin
                step(rb, ri);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
